// File: rtl/cve2_pkg.sv
// Shared core package: multiply/divide operator encoding, iterative MD FSM states
// and the magnitude helper used when preparing signed operands.
package cve2_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'b00,
        MD_INIT   = 2'b01,
        MD_ITER   = 2'b10,
        MD_FINISH = 2'b11
    } md_fsm_e;

    localparam int unsigned MD_ITERATIONS = 32;

    // Two's-complement magnitude; only negative values of signed operands are negated.
    function automatic logic [31:0] md_abs(input logic [31:0] value, input logic is_signed);
        logic [31:0] mag;
        if (is_signed && value[31]) begin
            mag = ~value + 32'd1;
        end else begin
            mag = value;
        end
        return mag;
    endfunction

endpackage

// File: rtl/cve2_md_addsub.sv
// 33-bit adder with optional operand inversion and explicit carry-in, shared by
// the multiply accumulate step, the trial subtraction and the final negation.
module cve2_md_addsub (
    input  logic [32:0] a_i,
    input  logic [32:0] b_i,
    input  logic        invert_b_i,
    input  logic        carry_in_i,
    output logic [32:0] sum_o,
    output logic        carry_out_o
);

    logic [32:0] b_eff_s;
    logic [33:0] full_s;

    assign b_eff_s     = invert_b_i ? ~b_i : b_i;
    assign full_s      = {1'b0, a_i} + {1'b0, b_eff_s} + {33'd0, carry_in_i};
    assign sum_o       = full_s[32:0];
    assign carry_out_o = full_s[33];

endmodule

// File: rtl/cve2_multdiv_iter.sv
// Iterative radix-2 multiply/divide unit for RV32M. Fixed 34-cycle latency unless
// ConstantTime is cleared, in which case trivial operands finish after 2 cycles.
module cve2_multdiv_iter
    import cve2_pkg::*;
#(
    parameter bit ConstantTime = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  md_op_e      operator_i,
    input  logic [1:0]  signed_mode_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic        busy_o
);

    localparam logic [4:0] CNT_INIT_C = 5'(MD_ITERATIONS - 1);

    md_fsm_e     state_r;
    md_fsm_e     state_next_s;
    md_op_e      op_r;
    logic [1:0]  signed_mode_r;
    logic [31:0] op_a_r;
    logic [31:0] op_b_r;
    logic [31:0] a_mag_r;
    logic [31:0] b_mag_r;
    logic [31:0] shift_r;
    logic [63:0] acc_r;
    logic [4:0]  cnt_r;
    logic        neg_res_r;
    logic [31:0] result_r;
    logic        valid_r;
    logic        busy_r;

    logic        sign_a_s;
    logic        sign_b_s;
    logic [31:0] a_abs_s;
    logic [31:0] b_abs_s;
    logic        is_mul_s;
    logic        a_zero_s;
    logic        b_zero_s;
    logic        early_exit_s;
    logic        neg_res_s;
    logic [32:0] rem_sh_s;
    logic [31:0] sel_s;
    logic [31:0] final_s;
    logic [32:0] add_a_s;
    logic [32:0] add_b_s;
    logic        add_inv_s;
    logic        add_cin_s;
    logic [32:0] add_sum_s;
    logic        add_cout_s;

    assign sign_a_s     = signed_mode_r[0] & op_a_r[31];
    assign sign_b_s     = signed_mode_r[1] & op_b_r[31];
    assign a_abs_s      = md_abs(op_a_r, signed_mode_r[0]);
    assign b_abs_s      = md_abs(op_b_r, signed_mode_r[1]);
    assign is_mul_s     = (op_r == MD_OP_MULL) || (op_r == MD_OP_MULH);
    assign a_zero_s     = (op_a_r == 32'd0);
    assign b_zero_s     = (op_b_r == 32'd0);
    assign early_exit_s = !ConstantTime && (is_mul_s ? (a_zero_s || b_zero_s) : b_zero_s);
    assign rem_sh_s     = {acc_r[63:32], shift_r[31]};
    assign sel_s        = ((op_r == MD_OP_MULH) || (op_r == MD_OP_REM)) ? acc_r[63:32] : acc_r[31:0];
    assign final_s      = neg_res_r ? add_sum_s[31:0] : sel_s;

    assign result_o = result_r;
    assign valid_o  = valid_r;
    assign busy_o   = busy_r;

    // Result sign: a zero divisor keeps the all-ones quotient unnegated.
    always_comb begin
        neg_res_s = 1'b0;
        case (op_r)
            MD_OP_MULL, MD_OP_MULH: neg_res_s = sign_a_s ^ sign_b_s;
            MD_OP_DIV:              neg_res_s = (sign_a_s ^ sign_b_s) & ~b_zero_s;
            MD_OP_REM:              neg_res_s = sign_a_s;
            default:                neg_res_s = 1'b0;
        endcase
    end

    // Shared adder operand steering for accumulate, trial subtract and negation.
    always_comb begin
        add_a_s   = 33'd0;
        add_b_s   = 33'd0;
        add_inv_s = 1'b0;
        add_cin_s = 1'b0;
        case (state_r)
            MD_ITER: begin
                if (is_mul_s) begin
                    add_a_s = {1'b0, acc_r[63:32]};
                    add_b_s = shift_r[0] ? {1'b0, a_mag_r} : 33'd0;
                end else begin
                    add_a_s   = rem_sh_s;
                    add_b_s   = {1'b0, b_mag_r};
                    add_inv_s = 1'b1;
                    add_cin_s = 1'b1;
                end
            end
            MD_FINISH: begin
                // Upper half of a 64-bit negation only carries in when the low half is zero.
                add_b_s   = {1'b0, sel_s};
                add_inv_s = 1'b1;
                if (op_r == MD_OP_MULH) begin
                    add_cin_s = (acc_r[31:0] == 32'd0);
                end else begin
                    add_cin_s = 1'b1;
                end
            end
            default: begin
                add_a_s = 33'd0;
            end
        endcase
    end

    cve2_md_addsub u_addsub (
        .a_i         (add_a_s),
        .b_i         (add_b_s),
        .invert_b_i  (add_inv_s),
        .carry_in_i  (add_cin_s),
        .sum_o       (add_sum_s),
        .carry_out_o (add_cout_s)
    );

    // Next-state logic; dropping en_i during INIT or ITER aborts.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            MD_IDLE: begin
                if (en_i) begin
                    state_next_s = MD_INIT;
                end else begin
                    state_next_s = MD_IDLE;
                end
            end
            MD_INIT: begin
                if (!en_i) begin
                    state_next_s = MD_IDLE;
                end else if (early_exit_s) begin
                    state_next_s = MD_FINISH;
                end else begin
                    state_next_s = MD_ITER;
                end
            end
            MD_ITER: begin
                if (!en_i) begin
                    state_next_s = MD_IDLE;
                end else if (cnt_r == 5'd0) begin
                    state_next_s = MD_FINISH;
                end else begin
                    state_next_s = MD_ITER;
                end
            end
            MD_FINISH: state_next_s = MD_IDLE;
            default:   state_next_s = MD_IDLE;
        endcase
    end

    // State register and registered handshake/result outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= MD_IDLE;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            result_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != MD_IDLE);
            valid_r <= (state_r == MD_FINISH);
            if (state_r == MD_FINISH) begin
                result_r <= final_s;
            end
        end
    end

    // Operand capture and iterative datapath.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_r          <= MD_OP_MULL;
            signed_mode_r <= 2'b00;
            op_a_r        <= 32'd0;
            op_b_r        <= 32'd0;
            a_mag_r       <= 32'd0;
            b_mag_r       <= 32'd0;
            shift_r       <= 32'd0;
            acc_r         <= 64'd0;
            cnt_r         <= 5'd0;
            neg_res_r     <= 1'b0;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (en_i) begin
                        op_r          <= operator_i;
                        signed_mode_r <= signed_mode_i;
                        op_a_r        <= op_a_i;
                        op_b_r        <= op_b_i;
                    end
                end
                MD_INIT: begin
                    a_mag_r   <= a_abs_s;
                    b_mag_r   <= b_abs_s;
                    neg_res_r <= neg_res_s;
                    cnt_r     <= CNT_INIT_C;
                    shift_r   <= is_mul_s ? b_abs_s : a_abs_s;
                    // Early divide-by-zero exit preloads what 32 iterations would produce.
                    if (early_exit_s && !is_mul_s) begin
                        acc_r <= {a_abs_s, 32'hFFFF_FFFF};
                    end else begin
                        acc_r <= 64'd0;
                    end
                end
                MD_ITER: begin
                    cnt_r <= cnt_r - 5'd1;
                    if (is_mul_s) begin
                        acc_r   <= {add_sum_s, acc_r[31:1]};
                        shift_r <= {1'b0, shift_r[31:1]};
                    end else begin
                        acc_r   <= {(add_cout_s ? add_sum_s[31:0] : rem_sh_s[31:0]),
                                    acc_r[30:0], add_cout_s};
                        shift_r <= {shift_r[30:0], 1'b0};
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule
